// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store front-end between the execute stage and a word-addressed data
// RAM. It takes one byte, halfword or word request at a time, performs
// sub-word stores as a read-modify-write of the containing word, returns
// sign- or zero-extended load data, and turns illegal-size, out-of-range and
// (optionally) misaligned requests into a fault response without touching
// the RAM.
//
// Build option:
//   MAU_MISALIGN_FAULT_EN  defined   -> a halfword with addr[0]=1 or a word
//                                       with addr[1:0]!=0 faults.
//                          undefined -> the offending low address bits are
//                                       forced to 0 and the access proceeds.
//
// Parameters:
//   MEM_BYTES       byte size of the attached RAM; addresses >= MEM_BYTES fault.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   reqValid/Ready  request handshake
//   reqWrite        1 = store, 0 = load
//   reqSize         00 byte, 01 halfword, 10 word, 11 illegal
//   reqUnsigned     loads: 1 = zero-extend, 0 = sign-extend
//   reqAddress      byte address
//   reqData         store data, right-aligned
//   respValid       one-cycle completion pulse
//   respData        extended load data (0 for stores and faults)
//   respFault       request rejected, no RAM write happened
//   ramWriteEnable  RAM write strobe (RAM commits on the following negedge)
//   ramReadEnable   RAM read strobe
//   ramAddress      word-aligned RAM address {addr[31:2], 2'b00}
//   ramDataOut      word written to the RAM
//   ramDataIn       word read from the RAM (combinational read)
//
// Handshake: a request transfers on a posedge where reqValid && reqReady are
// both high. reqReady is high only in IDLE and only while reset is low. The
// requester keeps reqValid and all req* fields stable until that edge; while
// the unit is busy the req* inputs are ignored because every field is
// latched at the transfer edge. respValid is a single-cycle pulse with no
// back-pressure; the next request can transfer in the cycle after it.
//
// The FSM state is held in state_q (type mau_state_e) for observation.
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respFault,
  output logic        ramWriteEnable,
  output logic        ramReadEnable,
  output logic [31:0] ramAddress,
  output logic [31:0] ramDataOut,
  input  logic [31:0] ramDataIn
);

  localparam logic [1:0]  SIZE_BYTE = 2'b00;
  localparam logic [1:0]  SIZE_HALF = 2'b01;
  localparam logic [1:0]  SIZE_WORD = 2'b10;
  localparam logic [1:0]  SIZE_ILL  = 2'b11;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } mau_state_e;

  mau_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        fault_q, fault_d;
  logic [31:0] read_buf_q, read_buf_d;

  logic        accept;
  logic        misaligned;
  logic        req_fault;
  logic [31:0] eff_addr;
  logic [31:0] aligned_addr;
  logic [31:0] merged_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // ---------------------------------------------------------------------------
  // Request decode (combinational on the live request fields)
  // ---------------------------------------------------------------------------
`ifdef MAU_MISALIGN_FAULT_EN
  always_comb begin
    misaligned = 1'b0;
    if (reqSize == SIZE_HALF && reqAddress[0]) begin
      misaligned = 1'b1;
    end
    if (reqSize == SIZE_WORD && reqAddress[1:0] != 2'b00) begin
      misaligned = 1'b1;
    end
    eff_addr = reqAddress;
  end
`else
  // Misaligned requests are silently rounded down to their natural alignment.
  always_comb begin
    misaligned = 1'b0;
    eff_addr   = reqAddress;
    if (reqSize == SIZE_HALF) begin
      eff_addr[0] = 1'b0;
    end
    if (reqSize == SIZE_WORD) begin
      eff_addr[1:0] = 2'b00;
    end
  end
`endif

  // Range check uses the address as presented; rounding down can never move
  // an in-range address out of range because MEM_BYTES is word-sized.
  assign req_fault = (reqSize == SIZE_ILL) || (reqAddress >= MEM_LIMIT) || misaligned;
  assign accept    = reqValid && reqReady;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      size_q     <= SIZE_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      fault_q    <= 1'b0;
      read_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      fault_q    <= fault_d;
      read_buf_q <= read_buf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    data_d     = data_q;
    fault_d    = fault_q;
    read_buf_d = read_buf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d    = reqWrite;
          size_d     = reqSize;
          unsigned_d = reqUnsigned;
          addr_d     = eff_addr;
          data_d     = reqData;
          fault_d    = req_fault;
          if (req_fault) begin
            state_d = ST_RESP;
          end else if (reqWrite && reqSize == SIZE_WORD) begin
            // Full-word stores need no merge, so the read is skipped.
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        read_buf_d = ramDataIn;
        state_d    = write_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store merge: new lane(s) from the store data, the rest from readBuf
  // ---------------------------------------------------------------------------
  always_comb begin
    merged_word = read_buf_q;
    case (size_q)
      SIZE_BYTE: begin
        case (addr_q[1:0])
          2'd0:    merged_word[7:0]   = data_q[7:0];
          2'd1:    merged_word[15:8]  = data_q[7:0];
          2'd2:    merged_word[23:16] = data_q[7:0];
          default: merged_word[31:24] = data_q[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (addr_q[1]) begin
          merged_word[31:16] = data_q[15:0];
        end else begin
          merged_word[15:0] = data_q[15:0];
        end
      end
      default: begin
        merged_word = data_q;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = read_buf_q[7:0];
      2'd1:    byte_sel = read_buf_q[15:8];
      2'd2:    byte_sel = read_buf_q[23:16];
      default: byte_sel = read_buf_q[31:24];
    endcase
    half_sel = addr_q[1] ? read_buf_q[31:16] : read_buf_q[15:0];

    case (size_q)
      SIZE_BYTE: load_data = {{24{!unsigned_q && byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = {{16{!unsigned_q && half_sel[15]}}, half_sel};
      default:   load_data = read_buf_q;
    endcase
  end

  assign aligned_addr = {addr_q[31:2], 2'b00};

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    reqReady       = (state_q == ST_IDLE) && !reset;
    respValid      = 1'b0;
    respData       = '0;
    respFault      = 1'b0;
    ramWriteEnable = 1'b0;
    ramReadEnable  = 1'b0;
    ramAddress     = '0;
    ramDataOut     = '0;

    unique case (state_q)
      ST_READ: begin
        ramReadEnable = 1'b1;
        ramAddress    = aligned_addr;
      end
      ST_WRITE: begin
        // Reset blocks the strobe in the same cycle so an interrupted
        // store never reaches the RAM.
        ramWriteEnable = !reset;
        ramAddress     = aligned_addr;
        ramDataOut     = merged_word;
      end
      ST_RESP: begin
        respValid = 1'b1;
        respFault = fault_q;
        respData  = (fault_q || write_q) ? 32'd0 : load_data;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int MEM_BYTES = 1024;
  localparam int WORDS     = MEM_BYTES / 4;
  localparam int N_RANDOM  = 300;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic reset;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT and attached RAM
  // ---------------------------------------------------------------------------
  logic        reqValid, reqReady, reqWrite, reqUnsigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddress, reqData;
  logic        respValid, respFault;
  logic [31:0] respData;
  logic        ramWriteEnable, ramReadEnable;
  logic [31:0] ramAddress, ramDataOut, ramDataIn;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk            (clk),
    .reset          (reset),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqWrite       (reqWrite),
    .reqSize        (reqSize),
    .reqUnsigned    (reqUnsigned),
    .reqAddress     (reqAddress),
    .reqData        (reqData),
    .respValid      (respValid),
    .respData       (respData),
    .respFault      (respFault),
    .ramWriteEnable (ramWriteEnable),
    .ramReadEnable  (ramReadEnable),
    .ramAddress     (ramAddress),
    .ramDataOut     (ramDataOut),
    .ramDataIn      (ramDataIn)
  );

  logic [31:0] ram [WORDS];
  logic [7:0]  ram_idx;
  logic        ram_clear;

  assign ram_idx   = ramAddress[9:2];
  assign ramDataIn = ram[ram_idx];

  always @(negedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= 32'd0;
    end else if (ramWriteEnable) begin
      ram[ram_idx] <= ramDataOut;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  logic        exp_fault_q[$];
  int          exp_lat_q[$];
  int          exp_wr_q[$];
  int          exp_rd_q[$];
  int          acc_q[$];

  int n_cmp = 0;
  int n_err = 0;
  logic mon_stop;

  logic [7:0] ref_mem [MEM_BYTES];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behavioural reference: byte-addressed memory, little-endian assembly.
  task automatic model(input logic w, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic f, output logic [31:0] r,
                       output int lat, output int nwr, output int nrd);
    int n;
    int ea;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    f = (sz == 2'd3) || (a >= 32'(MEM_BYTES));
`ifdef MAU_MISALIGN_FAULT_EN
    if ((a % 32'(n)) != 32'd0) f = 1'b1;
    ea = int'(a);
`else
    ea = int'(a - (a % 32'(n)));
`endif
    r = 32'd0;
    lat = 1;
    nwr = 0;
    nrd = 0;
    if (!f) begin
      if (w) begin
        for (int i = 0; i < n; i++) ref_mem[ea + i] = d[8*i +: 8];
        nwr = 1;
        nrd = (n < 4) ? 1 : 0;
        lat = (n < 4) ? 3 : 2;
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[ea + i]) << (8 * i));
        if (n < 4 && !un && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        r = v;
        nrd = 1;
        lat = 2;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic issue(input logic w, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic push, input logic has_exp, input logic [31:0] exp_c);
    int waited;
    logic f;
    logic [31:0] r;
    int lat, nwr, nrd;
    @(negedge clk);
    reqValid    = 1'b1;
    reqWrite    = w;
    reqSize     = sz;
    reqUnsigned = un;
    reqAddress  = a;
    reqData     = d;
    waited = 0;
    while (!reqReady && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!reqReady) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: reqReady=%0b after %0d cycles, required 1", reqReady, waited);
      reqValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (push) begin
      model(w, sz, un, a, d, f, r, lat, nwr, nrd);
      exp_q.push_back(has_exp ? exp_c : r);
      exp_fault_q.push_back(f);
      exp_lat_q.push_back(lat);
      exp_wr_q.push_back(nwr);
      exp_rd_q.push_back(nrd);
      acc_q.push_back(cyc);
    end
    // Fields change freely while the unit is busy; it must have latched them.
    reqValid    = 1'b0;
    reqWrite    = 1'($urandom);
    reqSize     = 2'($urandom);
    reqUnsigned = 1'($urandom);
    reqAddress  = $urandom;
    reqData     = $urandom;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence: reset, directed items, random traffic; monitor in parallel
  // ---------------------------------------------------------------------------
  initial begin
    int wr_cnt;
    int rd_cnt;
    reset = 1'b1;
    ram_clear = 1'b1;
    mon_stop = 1'b0;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqSize = 2'd0;
    reqUnsigned = 1'b0;
    reqAddress = 32'd0;
    reqData = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", 32'(reqReady), 32'd0);
    check("resp_valid_reset", 32'(respValid), 32'd0);
    check("resp_fault_reset", 32'(respFault), 32'd0);
    check("resp_data_reset", respData, 32'd0);
    check("ram_we_reset", 32'(ramWriteEnable), 32'd0);
    check("ram_re_reset", 32'(ramReadEnable), 32'd0);
    check("ram_addr_reset", ramAddress, 32'd0);
    check("ram_dout_reset", ramDataOut, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ram_clear = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(reqReady), 32'd1);

    fork
      begin : driver
        issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 1, 1, 32'h0);
        issue(0, 2'd2, 0, 32'h10, 32'h0, 1, 1, 32'hDEADBEEF);
        issue(1, 2'd2, 0, 32'h10, 32'h11223344, 1, 1, 32'h0);
        issue(1, 2'd0, 0, 32'h11, 32'h123456AA, 1, 1, 32'h0);
        issue(0, 2'd2, 0, 32'h10, 32'h0, 1, 1, 32'h1122AA44);
        issue(0, 2'd0, 0, 32'h11, 32'h0, 1, 1, 32'hFFFFFFAA);
        issue(0, 2'd0, 1, 32'h11, 32'h0, 1, 1, 32'h000000AA);
        issue(0, 2'd1, 0, 32'h12, 32'h0, 1, 1, 32'h00001122);
`ifdef MAU_MISALIGN_FAULT_EN
        issue(0, 2'd1, 0, 32'h13, 32'h0, 1, 1, 32'h0);
`else
        issue(0, 2'd1, 0, 32'h13, 32'h0, 1, 1, 32'h00001122);
`endif
        issue(1, 2'd2, 0, 32'(MEM_BYTES), 32'hCAFEF00D, 1, 1, 32'h0);
        issue(1, 2'd3, 0, 32'h0, 32'hCAFEF00D, 1, 1, 32'h0);

        // Interrupted byte store: reset lands in its WRITE cycle.
        issue(1, 2'd2, 0, 32'h20, 32'h55667788, 1, 1, 32'h0);
        issue(1, 2'd0, 0, 32'h20, 32'h00000099, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("we_suppressed_by_reset", 32'(ramWriteEnable), 32'd0);
        check("ready_low_in_reset", 32'(reqReady), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_mid_reset", 32'(reqReady), 32'd1);
        check("no_resp_after_reset", 32'(respValid), 32'd0);
        issue(0, 2'd2, 0, 32'h20, 32'h0, 1, 1, 32'h55667788);

        for (int k = 0; k < N_RANDOM; k++) begin
          int sel;
          logic [31:0] a;
          logic [1:0] sz;
          sel = $urandom_range(0, 19);
          if (sel < 17)      a = $urandom_range(0, 63);
          else if (sel < 19) a = $urandom_range(MEM_BYTES - 8, MEM_BYTES + 8);
          else               a = $urandom;
          sel = $urandom_range(0, 9);
          sz = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
          issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1, 0, 32'h0);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("pending_at_end", 32'(exp_q.size()), 32'd0);
        mon_stop = 1'b1;
      end

      begin : monitor
        wr_cnt = 0;
        rd_cnt = 0;
        while (!mon_stop) begin
          @(negedge clk);
          if (reset) begin
            wr_cnt = 0;
            rd_cnt = 0;
          end else begin
            if (ramWriteEnable) wr_cnt++;
            if (ramReadEnable) rd_cnt++;
            if (respValid) begin
              if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: respValid=1 with data 0x%08h, required no response", respData);
              end else begin
                check("resp_data", respData, exp_q.pop_front());
                check("resp_fault", 32'(respFault), 32'(exp_fault_q.pop_front()));
                check("latency", 32'(cyc - acc_q.pop_front() + 1), 32'(exp_lat_q.pop_front()));
                check("ram_write_cycles", 32'(wr_cnt), 32'(exp_wr_q.pop_front()));
                check("ram_read_cycles", 32'(rd_cnt), 32'(exp_rd_q.pop_front()));
              end
              wr_cnt = 0;
              rd_cnt = 0;
            end
          end
        end
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
